// File: rtl/dm_store_buffer.sv
// Store buffer: aligns SB/SH/SW stores into word writes with byte enables and drains them to data memory.
// Latency: a store accepted into an empty buffer is presented on mem_req the following cycle.
// Backpressure: st_ready drops when all entries are occupied (registered, independent of mem_ack); the head is held until mem_ack.
module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             st_valid,
   input  logic [3:0]       st_ctrl,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   output logic             st_ready,
   output logic             st_err,
   output logic [31:0]      st_err_addr,
   output logic             mem_req,
   output logic [31:0]      mem_addr,
   output logic [3:0]       mem_be,
   output logic [31:0]      mem_wdata,
   input  logic             mem_ack,
   output logic [PTR_W:0]   count,
   output logic             empty
);

   // Store control codes shared with the MEM-stage decoder.
   localparam logic [3:0] DM_SB = 4'd5;
   localparam logic [3:0] DM_SH = 4'd6;
   localparam logic [3:0] DM_SW = 4'd7;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   typedef struct packed {
      logic [29:0] waddr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } entry_t;

   entry_t            ent [DEPTH];
   entry_t            new_ent;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  tail_ptr;
   logic [PTR_W:0]    cnt;
   logic              is_store;
   logic              misalign;
   logic              accept;
   logic              do_pop;
   logic              do_push;
   logic              do_merge;

   assign count    = cnt;
   assign empty    = (cnt == '0);
   assign st_ready = (cnt != CNT_FULL);
   assign mem_req  = !empty;
   assign mem_addr = {ent[rd_ptr].waddr, 2'b00};
   assign mem_be   = ent[rd_ptr].be;
   assign mem_wdata = ent[rd_ptr].wdata;

   assign tail_ptr = wr_ptr - PTR_ONE;
   assign accept   = st_valid && st_ready;
   assign do_pop   = mem_req && mem_ack;
   // With two or more entries the tail is never the head, so a pop cannot
   // retire the tail in the same cycle; the head in flight is never merged.
   assign do_merge = accept && is_store && !misalign && (cnt >= CNT_TWO) &&
                     (ent[tail_ptr].waddr == st_addr[31:2]);
   assign do_push  = accept && is_store && !misalign && !do_merge;

   // Decode the store size into byte lanes and check natural alignment.
   always_comb begin
      is_store      = 1'b1;
      misalign      = 1'b0;
      new_ent.waddr = st_addr[31:2];
      new_ent.be    = 4'b0000;
      new_ent.wdata = 32'h0;
      case (st_ctrl)
         DM_SB: begin
            new_ent.be    = 4'b0001 << st_addr[1:0];
            new_ent.wdata = {4{st_data[7:0]}};
         end
         DM_SH: begin
            misalign      = st_addr[0];
            new_ent.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            new_ent.wdata = {2{st_data[15:0]}};
         end
         DM_SW: begin
            misalign      = |st_addr[1:0];
            new_ent.be    = 4'b1111;
            new_ent.wdata = st_data;
         end
         default: is_store = 1'b0;
      endcase
   end

   // Buffer storage, pointers and occupancy; merges update the tail in place.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      end else begin
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push) begin
            ent[wr_ptr] <= new_ent;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end else if (do_merge) begin
            ent[tail_ptr].be <= ent[tail_ptr].be | new_ent.be;
            for (int b = 0; b < 4; b++) begin
               if (new_ent.be[b]) ent[tail_ptr].wdata[8*b +: 8] <= new_ent.wdata[8*b +: 8];
            end
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: ;
         endcase
      end
   end

   // One-cycle error pulse and sticky address for dropped misaligned stores.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_err      <= 1'b0;
         st_err_addr <= 32'h0;
      end else begin
         st_err <= accept && is_store && misalign;
         if (accept && is_store && misalign) st_err_addr <= st_addr;
      end
   end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

   localparam int DEPTH = 4;
   localparam logic [3:0] SB = 4'd5;
   localparam logic [3:0] SH = 4'd6;
   localparam logic [3:0] SW = 4'd7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        st_valid;
   logic [3:0]  st_ctrl;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_ready;
   logic        st_err;
   logic [31:0] st_err_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [2:0]  count;
   logic        empty;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } ent_t;

   ent_t        sb_q[$];
   logic        err_exp;
   logic [31:0] err_addr_exp;

   always #5 clk = ~clk;

   dm_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .st_valid(st_valid), .st_ctrl(st_ctrl), .st_addr(st_addr), .st_data(st_data),
      .st_ready(st_ready), .st_err(st_err), .st_err_addr(st_err_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .count(count), .empty(empty)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
      st_valid = v;
      st_ctrl  = c;
      st_addr  = a;
      st_data  = d;
   endtask

   // One clock: check DUT against the scoreboard at the falling edge, advance the model, then cross the rising edge.
   task automatic step();
      logic acc, is_st, mis, mrg;
      ent_t e, t;
      int   n;
      @(negedge clk);
      n = sb_q.size();
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("mem_req", 32'(mem_req), 32'(n != 0));
      chk("st_ready", 32'(st_ready), 32'(n != DEPTH));
      chk("st_err", 32'(st_err), 32'(err_exp));
      if (err_exp) chk("st_err_addr", st_err_addr, err_addr_exp);
      if (n != 0) begin
         chk("mem_addr", mem_addr, sb_q[0].addr);
         chk("mem_be", 32'(mem_be), 32'(sb_q[0].be));
         chk("mem_wdata", mem_wdata, sb_q[0].wdata);
      end
      acc   = st_valid && (n != DEPTH);
      is_st = 1'b1;
      mis   = 1'b0;
      e.addr = {st_addr[31:2], 2'b00};
      e.be = 4'b0000;
      e.wdata = 32'h0;
      if (st_ctrl == SB) begin
         case (st_addr[1:0])
            2'd0: e.be = 4'b0001;
            2'd1: e.be = 4'b0010;
            2'd2: e.be = 4'b0100;
            default: e.be = 4'b1000;
         endcase
         e.wdata = st_data[7:0] * 32'h0101_0101;
      end else if (st_ctrl == SH) begin
         mis = st_addr[0];
         e.be = (st_addr[1:0] == 2'd2) ? 4'b1100 : 4'b0011;
         e.wdata = st_data[15:0] * 32'h0001_0001;
      end else if (st_ctrl == SW) begin
         mis = (st_addr[1:0] != 2'd0);
         e.be = 4'b1111;
         e.wdata = st_data;
      end else begin
         is_st = 1'b0;
      end
      err_exp = acc && is_st && mis;
      if (err_exp) err_addr_exp = st_addr;
      mrg = acc && is_st && !mis && (n >= 2) && (sb_q[n-1].addr == e.addr);
      if (mem_ack && n != 0) void'(sb_q.pop_front());
      if (mrg) begin
         t = sb_q[sb_q.size()-1];
         t.be = t.be | e.be;
         for (int b = 0; b < 4; b++)
            if (e.be[b]) t.wdata[8*b +: 8] = e.wdata[8*b +: 8];
         sb_q[sb_q.size()-1] = t;
      end else if (acc && is_st && !mis) begin
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      mem_ack = 1'b0;
      err_exp = 1'b0;
      err_addr_exp = 32'h0;
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_st_err", 32'(st_err), 32'd0);
      chk("rst_st_err_addr", st_err_addr, 32'd0);
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      reset_n = 1'b1;
      step();

      // 1: SB to top byte lane, one-cycle latency, then acked
      drive(1'b1, SB, 32'h0000_1003, 32'h0000_00A5);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      mem_ack = 1'b1;
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h0000_1000);
      chk("t1_mem_be", 32'(mem_be), 32'h8);
      chk("t1_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
      step();
      chk("t1_empty", 32'(empty), 32'd1);
      mem_ack = 1'b0;

      // 2: aligned SH upper half, then misaligned SH dropped, then a no-op ctrl
      drive(1'b1, SH, 32'h0000_2002, 32'h0000_BEEF);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("t2_mem_be", 32'(mem_be), 32'hC);
      chk("t2_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
      drive(1'b1, SH, 32'h0000_2001, 32'h0000_1234);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("t2_st_err", 32'(st_err), 32'd1);
      chk("t2_st_err_addr", st_err_addr, 32'h0000_2001);
      chk("t2_count", 32'(count), 32'd1);
      drive(1'b1, 4'd0, 32'h0000_2004, 32'hDEAD_BEEF);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("t2_st_err_pulse", 32'(st_err), 32'd0);
      chk("t2_noop_count", 32'(count), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;

      // 3: merge of two SBs into the tail word behind an in-flight SW
      drive(1'b1, SW, 32'h0000_3000, 32'h1122_3344);
      step();
      drive(1'b1, SB, 32'h0000_4000, 32'h0000_0055);
      step();
      drive(1'b1, SB, 32'h0000_4002, 32'h0000_0066);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("t3_count", 32'(count), 32'd2);
      mem_ack = 1'b1;
      step();
      chk("t3_tail_be", 32'(mem_be), 32'h5);
      chk("t3_tail_bytes", mem_wdata & 32'h00FF_00FF, 32'h0066_0055);
      step();
      mem_ack = 1'b0;

      // 4: fill, refuse a fifth push, then drain one per cycle
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, SW, 32'h0000_5000 + 32'(4*i), 32'hA000_0000 + 32'(i));
         step();
      end
      chk("t4_st_ready", 32'(st_ready), 32'd0);
      chk("t4_count", 32'(count), 32'd4);
      drive(1'b1, SW, 32'h0000_5010, 32'hA000_0004);
      step();
      chk("t4_fifth_refused", 32'(count), 32'd4);
      mem_ack = 1'b1;
      step();
      chk("t4_ready_after_pop", 32'(st_ready), 32'd1);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      repeat (5) step();
      chk("t4_drained", 32'(empty), 32'd1);
      mem_ack = 1'b0;

      // 5: steady push+pop at count 2 across pointer wrap
      drive(1'b1, SW, 32'h0000_6000, 32'h6000_0000);
      step();
      drive(1'b1, SW, 32'h0000_6004, 32'h6000_0004);
      step();
      mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, SW, 32'h0000_7000 + 32'(8*i), 32'h7000_0000 + 32'(i));
         step();
         chk("t5_count", 32'(count), 32'd2);
      end
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      repeat (3) step();
      mem_ack = 1'b0;

      // 6: asynchronous reset mid-drain with an error pulse pending
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, SW, 32'h0000_8010 + 32'(16*i), 32'h8000_0000 + 32'(i));
         step();
      end
      drive(1'b1, SW, 32'h0000_8001, 32'h0);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      chk("t6_pre_count", 32'(count), 32'd3);
      chk("t6_pre_err", 32'(st_err), 32'd1);
      mem_ack = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_mem_req", 32'(mem_req), 32'd0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_st_err", 32'(st_err), 32'd0);
      sb_q.delete();
      err_exp = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mem_ack = 1'b0;
      drive(1'b1, SB, 32'h0000_9001, 32'h0000_00C3);
      step();
      drive(1'b0, 4'd0, 32'h0, 32'h0);
      mem_ack = 1'b1;
      step();
      step();
      chk("t6_recovered_empty", 32'(empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
